// File: rtl/scanline_prefetcher.sv
// rtl/scanline_prefetcher.sv - ping-pong scanline prefetch from SDRAM feeding registered VGA pixels
module scanline_prefetcher #(
    parameter int               H_ACTIVE  = 640,
    parameter int               V_ACTIVE  = 480,
    parameter int               V_TOTAL   = 525,
    parameter int               ADDR_W    = 26,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              Reset_n,
    input  logic              pixel_en,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic              display_en,
    output logic [ADDR_W-1:0] bus_address,
    output logic              bus_read,
    input  logic              bus_acknowledge,
    input  logic [15:0]       bus_read_data,
    output logic [11:0]       pixel_out,
    output logic              fetch_busy,
    output logic              underrun
);
    localparam int COL_W = $clog2(H_ACTIVE);
    localparam int IDX_W = $clog2(2 * H_ACTIVE);

    typedef enum logic [1:0] {IDLE, REQ, GAP} state_t;

    state_t           state;
    logic [COL_W-1:0] col;
    logic [9:0]       target;
    logic             restart;
    logic             disp_sel;

    logic             trigger;
    logic [9:0]       next_line;
    logic             fetch_req;
    logic             disp_sel_next;
    logic             wr_en;
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] rd_idx;
    logic [3:0]       unused_hi;

    logic [11:0] line_mem [0:2*H_ACTIVE-1];

    assign unused_hi = bus_read_data[15:12];

    assign trigger   = pixel_en && (DrawX == 10'd0);
    assign next_line = (DrawY == 10'(V_TOTAL - 1)) ? 10'd0 : DrawY + 10'd1;
    assign fetch_req = trigger && (next_line < 10'(V_ACTIVE));
    // The swap takes effect for the read issued on the trigger cycle itself so DrawX=0 shows the new line.
    assign disp_sel_next = (trigger && (DrawY < 10'(V_ACTIVE))) ? ~disp_sel : disp_sel;

    function automatic logic [ADDR_W-1:0] word_addr(input logic [9:0] line, input logic [COL_W-1:0] c);
        return BASE_ADDR + ADDR_W'(line) * ADDR_W'(H_ACTIVE) + ADDR_W'(c);
    endfunction

    always_ff @(posedge clk) begin
        if (!Reset_n) begin
            state       <= IDLE;
            col         <= '0;
            target      <= '0;
            restart     <= 1'b0;
            disp_sel    <= 1'b0;
            bus_read    <= 1'b0;
            bus_address <= '0;
            fetch_busy  <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            disp_sel <= disp_sel_next;
            if (fetch_req && fetch_busy) begin
                // Late line: abandon the partial fetch, pass through one idle bus cycle, then restart at col 0.
                underrun <= 1'b1;
                state    <= GAP;
                bus_read <= 1'b0;
                target   <= next_line;
                restart  <= 1'b1;
            end else if (fetch_req) begin
                state       <= REQ;
                col         <= '0;
                target      <= next_line;
                bus_read    <= 1'b1;
                bus_address <= word_addr(next_line, '0);
                fetch_busy  <= 1'b1;
            end else begin
                case (state)
                    REQ: begin
                        if (bus_acknowledge) begin
                            state    <= GAP;
                            bus_read <= 1'b0;
                        end
                    end
                    GAP: begin
                        if (restart) begin
                            restart     <= 1'b0;
                            col         <= '0;
                            state       <= REQ;
                            bus_read    <= 1'b1;
                            bus_address <= word_addr(target, '0);
                        end else if (col == COL_W'(H_ACTIVE - 1)) begin
                            state      <= IDLE;
                            fetch_busy <= 1'b0;
                        end else begin
                            col         <= col + 1'b1;
                            state       <= REQ;
                            bus_read    <= 1'b1;
                            bus_address <= word_addr(target, col + 1'b1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign wr_en  = Reset_n && (state == REQ) && bus_acknowledge;
    assign wr_idx = disp_sel ? IDX_W'(col) : IDX_W'(col) + IDX_W'(H_ACTIVE);
    assign rd_idx = disp_sel_next ? IDX_W'(DrawX) + IDX_W'(H_ACTIVE) : IDX_W'(DrawX);

    always_ff @(posedge clk) begin
        if (wr_en) begin
            line_mem[wr_idx] <= bus_read_data[11:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!Reset_n) begin
            pixel_out <= 12'h000;
        end else if (display_en && (DrawX < 10'(H_ACTIVE))) begin
            pixel_out <= line_mem[rd_idx];
        end else begin
            pixel_out <= 12'h000;
        end
    end
endmodule

// File: tb/tb_scanline_prefetcher.sv
// tb/tb_scanline_prefetcher.sv - scoreboard bench for scanline_prefetcher
module tb_scanline_prefetcher;
    localparam int H = 640;

    logic        clk = 1'b0;
    logic        Reset_n, pixel_en, display_en, bus_acknowledge;
    logic [9:0]  DrawX, DrawY;
    logic [15:0] bus_read_data;
    logic [25:0] bus_address, bus_address_b;
    logic        bus_read, bus_read_b, fetch_busy, fetch_busy_b, underrun, underrun_b;
    logic [11:0] pixel_out, pixel_out_b;

    int passes = 0;
    int total  = 0;
    int exp_addr_q[$];
    logic [11:0] exp_pix_q[$];
    bit ack_en = 0;
    bit stray  = 1;
    int bus_read_highs = 0;
    int low_run = 0;
    bit word_seen = 0;

    always #5 clk = ~clk;

    scanline_prefetcher dut (
        .clk(clk), .Reset_n(Reset_n), .pixel_en(pixel_en), .DrawX(DrawX), .DrawY(DrawY),
        .display_en(display_en), .bus_address(bus_address), .bus_read(bus_read),
        .bus_acknowledge(bus_acknowledge), .bus_read_data(bus_read_data),
        .pixel_out(pixel_out), .fetch_busy(fetch_busy), .underrun(underrun)
    );

    scanline_prefetcher #(.BASE_ADDR(26'h100)) dut_b (
        .clk(clk), .Reset_n(Reset_n), .pixel_en(pixel_en), .DrawX(DrawX), .DrawY(DrawY),
        .display_en(display_en), .bus_address(bus_address_b), .bus_read(bus_read_b),
        .bus_acknowledge(bus_acknowledge), .bus_read_data(bus_read_data),
        .pixel_out(pixel_out_b), .fetch_busy(fetch_busy_b), .underrun(underrun_b)
    );

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [11:0] pix_val(input int line, input int col);
        int v;
        v = col + 16 * line;
        return v[11:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Memory model: acks 1-3 cycles into each request; word content depends on line and column.
    initial begin : responder
        int wcnt;
        bit seen;
        int a;
        wcnt = 0;
        seen = 0;
        bus_acknowledge = 1'b0;
        bus_read_data = 16'h0000;
        forever begin
            tick();
            bus_acknowledge = stray;
            if (ack_en && bus_read) begin
                if (!seen) begin
                    seen = 1;
                    wcnt = $urandom_range(1, 3);
                end
                if (wcnt == 0) begin
                    a = int'(bus_address);
                    bus_acknowledge = 1'b1;
                    bus_read_data = 16'hF000 | {4'h0, pix_val(a / H, a % H)};
                    seen = 0;
                end else begin
                    wcnt--;
                end
            end else begin
                seen = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (bus_read) begin
            bus_read_highs++;
            if (low_run > 0 && word_seen) chk("gap_len", low_run, 1);
            low_run = 0;
        end else begin
            low_run++;
        end
        if (bus_read && bus_acknowledge) begin
            word_seen = 1;
            if (exp_addr_q.size() == 0) begin
                total++;
                $display("FAIL addr_unexpected: got %0h expected none", bus_address);
            end else begin
                int e;
                e = exp_addr_q.pop_front();
                chk("addr", bus_address, e);
                chk("addr_base100", bus_address_b, e + 'h100);
                chk("read_base100", bus_read_b, 1);
            end
        end
        if (!fetch_busy) word_seen = 0;
    end

    initial begin : pixel_monitor
        forever begin
            @(posedge clk);
            #1;
            if (exp_pix_q.size() > 0) begin
                logic [11:0] e;
                e = exp_pix_q.pop_front();
                chk("pixel", pixel_out, e);
                chk("pixel_base100", pixel_out_b, e);
            end
        end
    end

    task automatic expect_fetch(input int y);
        int t;
        t = (y == 524) ? 0 : y + 1;
        exp_addr_q.delete();
        if (t < 480) for (int c = 0; c < H; c++) exp_addr_q.push_back(t * H + c);
    endtask

    task automatic trig(input int y);
        tick();
        pixel_en = 1; DrawX = 10'd0; DrawY = 10'(y); display_en = 0;
        expect_fetch(y);
        tick();
        pixel_en = 0;
    endtask

    task automatic show_line(input int y, input int nvis);
        for (int x = 0; x < 644; x++) begin
            tick();
            pixel_en = 1; DrawX = 10'(x); DrawY = 10'(y); display_en = (x < nvis);
            if (x == 0) expect_fetch(y);
            exp_pix_q.push_back((x < nvis && x < H) ? pix_val(y, x) : 12'h000);
        end
        tick();
        pixel_en = 0; display_en = 0;
    endtask

    task automatic wait_fetch(input string name);
        int n;
        n = 0;
        while (exp_addr_q.size() > 0 && n < 20000) begin
            tick();
            n++;
        end
        chk({name, "_in_time"}, n < 20000, 1);
        chk({name, "_busy_in_gap"}, fetch_busy, 1);
        chk({name, "_read_in_gap"}, bus_read, 0);
        tick();
        chk({name, "_busy_fall"}, fetch_busy, 0);
    endtask

    initial begin : stimulus
        int k;
        Reset_n = 0; pixel_en = 0; display_en = 0; DrawX = 0; DrawY = 0;
        tick();
        chk("rst_bus_read", bus_read, 0);
        chk("rst_bus_address", bus_address, 0);
        chk("rst_pixel", pixel_out, 0);
        chk("rst_underrun", underrun, 0);
        chk("rst_busy", fetch_busy, 0);
        chk("rst_busy_b", fetch_busy_b, 0);
        tick();
        Reset_n = 1; stray = 0; ack_en = 1;

        trig(524);
        repeat (20) tick();
        Reset_n = 0;
        tick();
        chk("midrst_bus_read", bus_read, 0);
        chk("midrst_busy", fetch_busy, 0);
        exp_addr_q.delete();
        stray = 1;
        tick();
        Reset_n = 1;
        repeat (3) tick();
        chk("post_rst_ack_ignored", bus_read, 0);
        stray = 0;
        repeat (2) tick();

        trig(524);
        wait_fetch("line0");
        show_line(0, 642);
        wait_fetch("line1");
        show_line(1, 642);

        ack_en = 0;
        repeat (3) tick();
        k = H - exp_addr_q.size();
        chk("pre_underrun", underrun, 0);
        ack_en = 1;
        show_line(2, k);
        chk("underrun_set", underrun, 1);
        wait_fetch("line3");
        show_line(3, 642);
        wait_fetch("line4");

        bus_read_highs = 0;
        stray = 1;
        for (int y = 479; y <= 523; y++) trig(y);
        stray = 0;
        repeat (3) tick();
        chk("blank_no_read", bus_read_highs, 0);
        chk("blank_not_busy", fetch_busy, 0);

        trig(524);
        chk("v524_read", bus_read, 1);
        chk("v524_addr", bus_address, 0);
        wait_fetch("line0b");
        chk("underrun_sticky", underrun, 1);
        chk("underrun_sticky_b", underrun_b, 1);
        repeat (3) tick();
        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule

// File: doc/scanline_prefetcher.md
Name: scanline_prefetcher

Overview:
- Sits between the SDRAM external bus and the VGA colour pins: replaces the direct read_data-to-VGA_R/G/B path.
- Prefetches the next visible scanline from SDRAM into a ping-pong line buffer while the current line is displayed.
- Delivers one registered 12-bit RGB pixel per clock, addressed by the vga_controller's DrawX/DrawY.

Parameters:
- H_ACTIVE, 640, visible pixels per line (words fetched per line).
- V_ACTIVE, 480, visible lines per frame.
- V_TOTAL, 525, total lines per frame including vertical blanking.
- BASE_ADDR, 26'h0, SDRAM word address of pixel (0,0).
- ADDR_W, 26, bus address width.

Ports:
- clk  input  1  system clock, 50 MHz.
- Reset_n  input  1  synchronous, active-low reset.
- pixel_en  input  1  one-cycle strobe per VGA pixel tick; DrawX/DrawY are valid on it.
- DrawX  input  10  current horizontal pixel counter.
- DrawY  input  10  current vertical line counter.
- display_en  input  1  high in the active video region.
- bus_address  output  ADDR_W  SDRAM word address.
- bus_read  output  1  read request.
- bus_acknowledge  input  1  one-cycle acknowledge; bus_read_data is valid in the same cycle.
- bus_read_data  input  16  read word; bits [11:0] = {R,G,B}, bits [15:12] ignored.
- pixel_out  output  12  {R[3:0],G[3:0],B[3:0]} to the VGA pins.
- fetch_busy  output  1  high while a line fetch is in progress.
- underrun  output  1  sticky error flag.

Behaviour:
- Reset (clk edge with Reset_n=0):
  - bus_read=0, bus_address=0, pixel_out=0, fetch_busy=0, underrun=0.
  - Display-buffer select=0; FSM=IDLE.
  - Buffer contents are not reset.
- Line trigger: a pixel_en cycle with DrawX==0.
  - On a trigger, target line T = DrawY+1, or 0 when DrawY==V_TOTAL-1.
  - If DrawY<V_ACTIVE, the display select toggles so the buffer filled last line becomes the display buffer.
  - If T<V_ACTIVE, a fetch of line T into the non-display buffer starts on the next cycle.
  - Line 0 is therefore fetched during line V_TOTAL-1.
- Fetch FSM states: IDLE, REQ, GAP.
  - IDLE -> REQ on start: col=0, fetch_busy=1.
  - REQ: bus_read=1, bus_address = BASE_ADDR + T*H_ACTIVE + col, computed in ADDR_W bits. Address and read are held stable until bus_acknowledge=1.
  - On ack: bus_read_data[11:0] is written to fill_buf[col], then FSM -> GAP.
  - GAP: bus_read=0 for exactly one cycle.
    - If col==H_ACTIVE-1: -> IDLE, fetch_busy=0.
    - Otherwise: col+1, -> REQ.
  - An ack seen outside REQ is ignored.
- Underrun: a trigger that requests a fetch while fetch_busy=1 does the following:
  - Sets underrun=1; it clears only on reset.
  - Aborts the current fetch: bus_read=0 next cycle, then a one-cycle GAP.
  - Restarts with col=0 for the new target.
  - The buffer swap still occurs.
- Pixel path: pixel_out <= display_en ? disp_buf[DrawX] : 12'h000.
  - Latency is one clk from DrawX to pixel_out; the output is registered.
  - DrawX>=H_ACTIVE while display_en=1 outputs 0.
- Simultaneous trigger and ack in REQ: the ack's word is written, then the trigger's abort/restart takes priority over the GAP transition.
- Reset mid-fetch: bus_read drops at that edge; an ack arriving afterward is ignored.
- Buffers: 2 x H_ACTIVE x 12 bits, inferred block RAM, one write port and one read port.

Test Plan:
- Reset_n=0 for 2 clks with bus_read and ack activity -> bus_read=0, pixel_out=0, underrun=0, fetch_busy=0 the cycle after the first reset edge.
- Trigger at DrawY=524, ack returns 16'hF000|col after 1-3 wait cycles -> addresses are 0..639 in order; bus_read is low exactly 1 cycle between words; fetch_busy falls after word 639.
- Trigger at DrawY=0 with BASE_ADDR=26'h100 -> first bus_address=26'h100+640=26'h380; last =26'h5FF.
- After line 0 is filled with word=col, trigger at DrawY=0, step DrawX 0..639 with display_en=1 -> pixel_out=DrawX[11:0] one clk later; display_en=0 -> 12'h000.
- Ack withheld so a fetch is incomplete at the next trigger -> underrun=1 and stays 1; new fetch restarts at col 0 of the new line; swap occurs.
- Triggers at DrawY=479..523 -> no bus_read asserted; fetch of line 0 starts at DrawY=524.
